// File: rtl/interrupt_controller_if.sv
// CPU-side bus, instruction strobes and dispatch handshake of the interrupt controller.
interface interrupt_controller_if #(
  parameter int unsigned NUM_IRQ = 5
);
  logic               i_Enable;
  logic [NUM_IRQ-1:0] i_Irq;
  logic [15:0]        i_Address;
  logic               i_Write;
  logic               i_Read;
  logic [7:0]         i_Data;
  logic [7:0]         o_Data;
  logic               i_Ei;
  logic               i_Di;
  logic               i_Reti;
  logic               i_Instr_Done;
  logic               o_Irq_Request;
  logic               i_Ack;
  logic [15:0]        o_Vector;
  logic               o_Vector_Valid;
  logic               o_Wake;

  // CPU / control-unit side
  modport master (
    output i_Enable, i_Irq, i_Address, i_Write, i_Read, i_Data,
    output i_Ei, i_Di, i_Reti, i_Instr_Done, i_Ack,
    input  o_Data, o_Irq_Request, o_Vector, o_Vector_Valid, o_Wake
  );

  // Interrupt controller side
  modport slave (
    input  i_Enable, i_Irq, i_Address, i_Write, i_Read, i_Data,
    input  i_Ei, i_Di, i_Reti, i_Instr_Done, i_Ack,
    output o_Data, o_Irq_Request, o_Vector, o_Vector_Valid, o_Wake
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, edge-triggered interrupt controller with IF/IE registers,
// delayed-EI master enable and a request/ack/vector dispatch handshake.
module interrupt_controller #(
  parameter int unsigned NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8,
  parameter logic [15:0] IF_ADDR       = 16'hFF0F,
  parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
  input logic                   i_Clk,
  input logic                   i_Rst_n,
  interrupt_controller_if.slave bus
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VECTOR = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               ime_dly_q, ime_dly_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic [15:0]        vec_q, vec_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] edges;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         rd_if;
  logic               irq_req;
  logic               take;
  logic               wr_if;
  logic               wr_ie;

  assign pending = if_q & ie_q[NUM_IRQ-1:0];
  assign edges   = bus.i_Irq & ~irq_q;
  assign wr_if   = bus.i_Write && (bus.i_Address == IF_ADDR);
  assign wr_ie   = bus.i_Write && (bus.i_Address == IE_ADDR);

  // Lowest-numbered pending channel has the highest priority
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  // Read data mux; unimplemented IF bits read back as 1
  always_comb begin
    rd_if              = 8'hFF;
    rd_if[NUM_IRQ-1:0] = if_q;
    data_d             = 8'h00;
    if (bus.i_Read) begin
      if (bus.i_Address == IF_ADDR)      data_d = rd_if;
      else if (bus.i_Address == IE_ADDR) data_d = ie_q;
    end
  end

  // Dispatch FSM next state plus IF/IE/IME next-state logic
  always_comb begin
    state_d   = state_q;
    if_d      = if_q;
    ie_d      = ie_q;
    ime_d     = ime_q;
    ime_dly_d = ime_dly_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    irq_req   = 1'b0;
    take      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        irq_req = ime_q & (|pending);
        if (irq_req && bus.i_Ack) begin
          take    = 1'b1;
          idx_d   = sel_idx;
          vec_d   = VECTOR_BASE + 16'(sel_idx) * 16'(VECTOR_STRIDE);
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!bus.i_Ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes first, then capture clear; a fresh edge always wins
    if (wr_if) if_d = bus.i_Data[NUM_IRQ-1:0];
    if (wr_ie) ie_d = bus.i_Data;
    if (take)  if_d = if_d & ~(NUM_IRQ'(1) << sel_idx);
    if_d = if_d | edges;

    // EI takes effect one instruction late; DI and dispatch cancel it
    if (bus.i_Instr_Done && ime_dly_q) begin
      ime_d     = 1'b1;
      ime_dly_d = 1'b0;
    end
    if (bus.i_Ei)   ime_dly_d = 1'b1;
    if (bus.i_Reti) ime_d     = 1'b1;
    if (bus.i_Di || take) begin
      ime_d     = 1'b0;
      ime_dly_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)          state_q <= ST_IDLE;
    else if (bus.i_Enable) state_q <= state_d;
  end

  // Interrupt registers, edge history and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      if_q      <= '0;
      ie_q      <= 8'h00;
      ime_q     <= 1'b0;
      ime_dly_q <= 1'b0;
      irq_q     <= '0;
      idx_q     <= '0;
      data_q    <= 8'h00;
      vec_q     <= 16'h0000;
    end else if (bus.i_Enable) begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      ime_q     <= ime_d;
      ime_dly_q <= ime_dly_d;
      irq_q     <= bus.i_Irq;
      idx_q     <= idx_d;
      data_q    <= data_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.o_Data         = data_q;
  assign bus.o_Vector       = vec_q;
  assign bus.o_Vector_Valid = (state_q == ST_VECTOR);
  assign bus.o_Irq_Request  = irq_req;
  assign bus.o_Wake         = |pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller with a behavioural model.
module tb_interrupt_controller;

  localparam int unsigned N      = 5;
  localparam logic [15:0] BASE   = 16'h0040;
  localparam int unsigned STRIDE = 8;
  localparam logic [15:0] IFA    = 16'hFF0F;
  localparam logic [15:0] IEA    = 16'hFFFF;
  localparam int          MASK   = (1 << N) - 1;

  localparam int PH_IDLE = 0;
  localparam int PH_VEC  = 1;
  localparam int PH_HOLD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_IRQ(N)) bus ();

  interrupt_controller #(
    .NUM_IRQ      (N),
    .VECTOR_BASE  (BASE),
    .VECTOR_STRIDE(STRIDE),
    .IF_ADDR      (IFA),
    .IE_ADDR      (IEA)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: register contents and dispatch phase as plain integers
  int m_if, m_ie, m_ime, m_arm, m_hist, m_phase, m_vec, m_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_set(input int v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic int model_pending();
    return m_if & m_ie & MASK;
  endfunction

  function automatic logic exp_req();
    return (m_phase == PH_IDLE) && (m_ime != 0) && (model_pending() != 0);
  endfunction

  function automatic void model_reset();
    m_if = 0; m_ie = 0; m_ime = 0; m_arm = 0; m_hist = 0;
    m_phase = PH_IDLE; m_vec = 0; m_data = 0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus
  function automatic void model_step();
    int  pend, edges, nif, nie, nime, narm, k;
    bit  take;
    if (!bus.i_Enable) return;
    pend  = model_pending();
    edges = int'(bus.i_Irq) & ~m_hist & MASK;
    take  = exp_req() && bus.i_Ack;

    if (!bus.i_Read)              m_data_next(0);
    else if (bus.i_Address == IFA) m_data_next(m_if | (~MASK & 8'hFF));
    else if (bus.i_Address == IEA) m_data_next(m_ie);
    else                           m_data_next(0);

    nif = m_if;
    nie = m_ie;
    if (bus.i_Write && bus.i_Address == IFA) nif = int'(bus.i_Data) & MASK;
    if (bus.i_Write && bus.i_Address == IEA) nie = int'(bus.i_Data);

    nime = m_ime;
    narm = m_arm;
    if (bus.i_Instr_Done && m_arm != 0) begin nime = 1; narm = 0; end
    if (bus.i_Ei)   narm = 1;
    if (bus.i_Reti) nime = 1;
    if (bus.i_Di || take) begin nime = 0; narm = 0; end

    case (m_phase)
      PH_IDLE: if (take) begin
        k       = lowest_set(pend);
        nif     = nif & ~(1 << k);
        m_vec   = (int'(BASE) + k * int'(STRIDE)) % 65536;
        m_phase = PH_VEC;
      end
      PH_VEC:  m_phase = PH_HOLD;
      default: if (!bus.i_Ack) m_phase = PH_IDLE;
    endcase

    m_if   = nif | edges;
    m_ie   = nie;
    m_ime  = nime;
    m_arm  = narm;
    m_hist = int'(bus.i_Irq);
  endfunction

  function automatic void m_data_next(input int v);
    m_data = v;
  endfunction

  task automatic compare_all();
    check_eq("irq_request",  bus.o_Irq_Request,  exp_req());
    check_eq("wake",         bus.o_Wake,         model_pending() != 0);
    check_eq("vector_valid", bus.o_Vector_Valid, m_phase == PH_VEC);
    check_eq("vector",       bus.o_Vector,       m_vec);
    check_eq("rdata",        bus.o_Data,         m_data);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    bus.i_Write = 1'b0; bus.i_Read = 1'b0; bus.i_Ei = 1'b0; bus.i_Di = 1'b0;
    bus.i_Reti = 1'b0; bus.i_Instr_Done = 1'b0; bus.i_Ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.i_Write = 1'b1; bus.i_Address = a; bus.i_Data = d;
    tick();
  endtask

  task automatic bus_read(input logic [15:0] a);
    bus.i_Read = 1'b1; bus.i_Address = a;
    tick();
  endtask

  initial begin
    int r;
    bus.i_Enable = 1'b1; bus.i_Irq = '0; bus.i_Address = '0; bus.i_Write = 1'b0;
    bus.i_Read = 1'b0; bus.i_Data = '0; bus.i_Ei = 1'b0; bus.i_Di = 1'b0;
    bus.i_Reti = 1'b0; bus.i_Instr_Done = 1'b0; bus.i_Ack = 1'b0;
    do_reset();

    // Delayed EI, single channel dispatch
    bus_write(IEA, 8'h1F);
    bus.i_Ei = 1'b1; bus.i_Instr_Done = 1'b1; tick();
    bus.i_Instr_Done = 1'b1; tick();
    bus.i_Irq = 5'b00100; tick();
    check_eq("req_ch2", bus.o_Irq_Request, 1'b1);
    bus.i_Ack = 1'b1; tick();
    check_eq("vv_ch2", bus.o_Vector_Valid, 1'b1);
    check_eq("vec_ch2", bus.o_Vector, 16'h0050);
    bus.i_Irq = '0; tick();
    check_eq("vv_one_cycle", bus.o_Vector_Valid, 1'b0);
    tick();
    bus_read(IFA);
    check_eq("if_after_ch2", bus.o_Data, 8'hE0);
    check_eq("ime_cleared", bus.o_Irq_Request, 1'b0);

    // Two simultaneous sources, priority then RETI re-dispatch
    bus.i_Reti = 1'b1; tick();
    bus.i_Irq = 5'b10010; tick();
    check_eq("req_two", bus.o_Irq_Request, 1'b1);
    bus.i_Ack = 1'b1; tick();
    check_eq("vec_ch1", bus.o_Vector, 16'h0048);
    bus.i_Irq = '0; tick();
    tick();
    bus_read(IFA);
    check_eq("if_after_ch1", bus.o_Data, 8'hF0);
    bus.i_Reti = 1'b1; tick();
    check_eq("req_after_reti", bus.o_Irq_Request, 1'b1);
    bus.i_Ack = 1'b1; tick();
    check_eq("vec_ch4", bus.o_Vector, 16'h0060);
    tick();
    tick();

    // Wake without IME
    bus_write(IEA, 8'h01);
    bus.i_Irq = 5'b00001; tick();
    check_eq("wake_no_ime", bus.o_Wake, 1'b1);
    check_eq("no_req_no_ime", bus.o_Irq_Request, 1'b0);
    bus.i_Irq = '0; tick();

    // Edge beats a same-cycle IF write
    bus.i_Irq = 5'b01000; bus_write(IFA, 8'h00);
    bus_read(IFA);
    check_eq("if_edge_wins", bus.o_Data, 8'hE8);

    // EI delay and DI+EI collision
    bus_write(IEA, 8'h1F);
    bus_write(IFA, 8'h00);
    bus.i_Irq = '0; tick();
    bus.i_Ei = 1'b1; bus.i_Instr_Done = 1'b1; tick();
    bus.i_Irq = 5'b00001; tick();
    check_eq("ei_delay_a", bus.o_Irq_Request, 1'b0);
    tick();
    check_eq("ei_delay_b", bus.o_Irq_Request, 1'b0);
    bus.i_Instr_Done = 1'b1; tick();
    check_eq("ei_effective", bus.o_Irq_Request, 1'b1);
    bus.i_Di = 1'b1; bus.i_Ei = 1'b1; tick();
    check_eq("di_wins", bus.o_Irq_Request, 1'b0);
    bus.i_Instr_Done = 1'b1; tick();
    bus.i_Instr_Done = 1'b1; tick();
    check_eq("di_wins_late", bus.o_Irq_Request, 1'b0);

    // Reset during VECTOR; source held high across reset
    bus.i_Reti = 1'b1; tick();
    bus.i_Ack = 1'b1; tick();
    check_eq("vv_pre_reset", bus.o_Vector_Valid, 1'b1);
    check_eq("vec_ch0", bus.o_Vector, 16'h0040);
    bus.i_Irq = 5'b00010;
    do_reset();
    check_eq("vec_in_reset", bus.o_Vector, 16'h0000);
    tick();
    check_eq("no_vv_after_reset", bus.o_Vector_Valid, 1'b0);
    bus_read(IFA);
    check_eq("if_held_source", bus.o_Data, 8'hE2);
    check_eq("no_vv_after_reset2", bus.o_Vector_Valid, 1'b0);

    // Randomised traffic including disabled cycles
    for (int c = 0; c < 3000; c++) begin
      bus.i_Enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) bus.i_Irq = N'($urandom);
      r = $urandom_range(0, 3);
      bus.i_Address    = (r == 0) ? IFA : (r == 1) ? IEA : 16'($urandom);
      bus.i_Write      = ($urandom_range(0, 7) == 0);
      bus.i_Read       = ($urandom_range(0, 2) == 0);
      bus.i_Data       = 8'($urandom);
      bus.i_Ei         = ($urandom_range(0, 7) == 0);
      bus.i_Di         = ($urandom_range(0, 15) == 0);
      bus.i_Reti       = ($urandom_range(0, 9) == 0);
      bus.i_Instr_Done = ($urandom_range(0, 2) == 0);
      bus.i_Ack        = ($urandom_range(0, 2) == 0);
      tick();
      if (c % 1000 == 999) begin
        bus.i_Enable = 1'b1;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
